// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with standard/FWFT read, water level and sticky error flags
//
// Ports:
//   clk, rst                 single clock (rising edge), asynchronous active-high reset
//   wr_en, wr_data, wr_full  write side; writes while full are dropped
//   rd_en, rd_data, rd_empty read side; FWFT=1 presents the head without rd_en
//   almost_full/almost_empty threshold flags on water_level
//   water_level              entries held (FWFT: RAM entries plus output register)
//   overflow, underflow      sticky error flags, cleared only by rst
//   peak_clr, peak_level     only with SYNC_FIFO_PEAK_LEVEL_EN defined: max water_level tracker
module sync_fifo_param #(
    parameter int DATA_WIDTH       = 8,
    parameter int DEPTH_WIDTH      = 11,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4,
    parameter int FWFT             = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_empty,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   water_level,
    output logic                   overflow,
    output logic                   underflow
`ifdef SYNC_FIFO_PEAK_LEVEL_EN
    ,
    input  logic                   peak_clr,
    output logic [DEPTH_WIDTH:0]   peak_level
`endif
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0]   DEPTH_LVL = (DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0]   AF_LVL    = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [DEPTH_WIDTH:0]   AE_LVL    = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
    localparam logic [DEPTH_WIDTH:0]   LVL_ONE   = (DEPTH_WIDTH+1)'(1);
    localparam logic [DEPTH_WIDTH:0]   LVL_ZERO  = '0;
    localparam logic [DEPTH_WIDTH-1:0] PTR_ONE   = (DEPTH_WIDTH)'(1);
    localparam bit                     FWFT_MODE = (FWFT != 0);

    if (DEPTH_WIDTH < 2 || DEPTH_WIDTH > 20 || DATA_WIDTH < 1 || DATA_WIDTH > 1152 ||
        ALMOST_FULL_NUM < 1 || ALMOST_FULL_NUM > DEPTH ||
        ALMOST_EMPTY_NUM < 0 || ALMOST_EMPTY_NUM > DEPTH - 1 ||
        FWFT < 0 || FWFT > 1) begin : g_param_check
        $error("sync_fifo_param: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH:0]   level;      // total entries, including the FWFT output register
    logic                   out_valid;  // FWFT output register holds the head; always 0 in standard mode

    logic wr_acc;
    logic rd_dec;
    logic ram_has;
    logic ram_rd;
    logic [DEPTH_WIDTH:0] level_nxt;

    assign wr_full      = (level == DEPTH_LVL);
    assign rd_empty     = FWFT_MODE ? ~out_valid : (level == LVL_ZERO);
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);
    assign water_level  = level;

    assign wr_acc = wr_en & ~wr_full;
    // An accepted read removes one entry from the FIFO in both modes.
    assign rd_dec = rd_en & ~rd_empty;
    // RAM occupancy is the total level minus whatever sits in the output register.
    assign ram_has = (level != {{DEPTH_WIDTH{1'b0}}, out_valid});
    // Standard mode reads RAM on every accepted read; FWFT refills the output
    // register whenever it is empty or being popped, so consecutive pops see no bubble.
    assign ram_rd = FWFT_MODE ? (ram_has & (~out_valid | rd_dec)) : rd_dec;

    always_comb begin
        level_nxt = level;
        if (wr_acc && !rd_dec) begin
            level_nxt = level + LVL_ONE;
        end else if (!wr_acc && rd_dec) begin
            level_nxt = level - LVL_ONE;
        end
    end

    // RAM array has no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            level <= level_nxt;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ram_rd) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
            if (FWFT_MODE) begin
                if (ram_rd) begin
                    out_valid <= 1'b1;
                end else if (rd_dec) begin
                    out_valid <= 1'b0;
                end
            end
            if (wr_en && wr_full) begin
                overflow <= 1'b1;
            end
            if (rd_en && rd_empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_PEAK_LEVEL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_level <= '0;
        end else if (peak_clr) begin
            peak_level <= level;
        end else if (level > peak_level) begin
            peak_level <= level;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param in standard and FWFT modes
module tb_sync_fifo_param;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int DEP = 16;
    localparam int AFN = 14;
    localparam int AEN = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic          s_full, s_afull, s_empty, s_aempty, s_of, s_uf;
    logic [DW-1:0] s_rd_data;
    logic [AW:0]   s_level;
    logic          f_full, f_afull, f_empty, f_aempty, f_of, f_uf;
    logic [DW-1:0] f_rd_data;
    logic [AW:0]   f_level;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .ALMOST_FULL_NUM(AFN),
                      .ALMOST_EMPTY_NUM(AEN), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(s_full),
        .almost_full(s_afull), .rd_en(rd_en), .rd_data(s_rd_data), .rd_empty(s_empty),
        .almost_empty(s_aempty), .water_level(s_level), .overflow(s_of), .underflow(s_uf)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .ALMOST_FULL_NUM(AFN),
                      .ALMOST_EMPTY_NUM(AEN), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(f_full),
        .almost_full(f_afull), .rd_en(rd_en), .rd_data(f_rd_data), .rd_empty(f_empty),
        .almost_empty(f_aempty), .water_level(f_level), .overflow(f_of), .underflow(f_uf)
    );

    // Reference model: a queue of held words per mode; FWFT adds a head-visible bit.
    logic [DW-1:0] qs[$];
    logic [DW-1:0] qf[$];
    logic [DW-1:0] exp_rd_s;
    bit of_s, uf_s, of_f, uf_f, ov_f;

    always @(posedge clk or posedge rst) begin : model
        bit wa, ra, pop;
        int ram;
        if (rst) begin
            qs.delete();
            qf.delete();
            exp_rd_s = '0;
            of_s = 0; uf_s = 0; of_f = 0; uf_f = 0; ov_f = 0;
        end else begin
            wa = wr_en && (qs.size() < DEP);
            ra = rd_en && (qs.size() > 0);
            if (wr_en && !wa) of_s = 1;
            if (rd_en && !ra) uf_s = 1;
            if (ra) exp_rd_s = qs.pop_front();
            if (wa) qs.push_back(wr_data);

            wa  = wr_en && (qf.size() < DEP);
            pop = rd_en && ov_f;
            if (wr_en && !wa) of_f = 1;
            if (rd_en && !ov_f) uf_f = 1;
            ram = qf.size() - (ov_f ? 1 : 0);
            if (pop) void'(qf.pop_front());
            ov_f = (ov_f && !pop) ? 1'b1 : (ram > 0);
            if (wa) qf.push_back(wr_data);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("s_level",   64'(s_level),   64'(qs.size()));
            chk("s_full",    64'(s_full),    64'(qs.size() == DEP));
            chk("s_afull",   64'(s_afull),   64'(qs.size() >= AFN));
            chk("s_aempty",  64'(s_aempty),  64'(qs.size() <= AEN));
            chk("s_empty",   64'(s_empty),   64'(qs.size() == 0));
            chk("s_rd_data", 64'(s_rd_data), 64'(exp_rd_s));
            chk("s_of",      64'(s_of),      64'(of_s));
            chk("s_uf",      64'(s_uf),      64'(uf_s));
            chk("f_level",   64'(f_level),   64'(qf.size()));
            chk("f_full",    64'(f_full),    64'(qf.size() == DEP));
            chk("f_afull",   64'(f_afull),   64'(qf.size() >= AFN));
            chk("f_aempty",  64'(f_aempty),  64'(qf.size() <= AEN));
            chk("f_empty",   64'(f_empty),   64'(!ov_f));
            chk("f_of",      64'(f_of),      64'(of_f));
            chk("f_uf",      64'(f_uf),      64'(uf_f));
            if (ov_f) chk("f_rd_data", 64'(f_rd_data), 64'(qf[0]));
        end
    end

    task automatic cyc(input bit we, input logic [DW-1:0] wd, input bit re);
        wr_en = we; wr_data = wd; rd_en = re;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        started = 1;
        chk("rst_s_full",   64'(s_full),    64'd0);
        chk("rst_s_afull",  64'(s_afull),   64'd0);
        chk("rst_s_empty",  64'(s_empty),   64'd1);
        chk("rst_s_aempty", 64'(s_aempty),  64'd1);
        chk("rst_s_level",  64'(s_level),   64'd0);
        chk("rst_s_rd",     64'(s_rd_data), 64'd0);
        chk("rst_f_empty",  64'(f_empty),   64'd1);
        rst = 1'b0;

        // read from empty
        cyc(0, 8'h00, 1);
        chk("uf_s",       64'(s_uf),      64'd1);
        chk("uf_s_rd",    64'(s_rd_data), 64'd0);
        chk("uf_s_empty", 64'(s_empty),   64'd1);
        chk("uf_s_level", 64'(s_level),   64'd0);
        do_reset();

        // fill to full, overflow, drain in order
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 8'(i), 0);
            if (i == 13) chk("af_13", 64'(s_afull), 64'd0);
            if (i == 14) chk("af_14", 64'(s_afull), 64'd1);
        end
        chk("full_s",   64'(s_full),  64'd1);
        chk("full_lvl", 64'(s_level), 64'd16);
        chk("full_f",   64'(f_full),  64'd1);
        cyc(1, 8'h11, 0);
        chk("of_s",     64'(s_of),    64'd1);
        chk("of_f",     64'(f_of),    64'd1);
        chk("of_lvl",   64'(s_level), 64'd16);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_f_head", 64'(f_rd_data), 64'(i));
            cyc(0, 8'h00, 1);
            chk("drain_s_rd", 64'(s_rd_data), 64'(i));
            if (i == 13) chk("ae_3", 64'(s_aempty), 64'd0);
            if (i == 14) chk("ae_2", 64'(s_aempty), 64'd1);
        end
        chk("drain_empty", 64'(s_empty), 64'd1);
        do_reset();

        // FWFT single word
        cyc(1, 8'hA5, 0);
        chk("fw_lat_empty", 64'(f_empty),   64'd1);
        cyc(0, 8'h00, 0);
        chk("fw_empty",     64'(f_empty),   64'd0);
        chk("fw_data",      64'(f_rd_data), 64'hA5);
        chk("fw_lvl1",      64'(f_level),   64'd1);
        cyc(0, 8'h00, 1);
        chk("fw_pop_empty", 64'(f_empty),   64'd1);
        chk("fw_lvl0",      64'(f_level),   64'd0);
        do_reset();

        // half full streaming across pointer wrap
        for (int i = 0; i < 8; i++) cyc(1, 8'(8'h20 + i), 0);
        cyc(0, 8'h00, 0);
        for (int k = 0; k < 100; k++) begin
            cyc(1, 8'(8'h40 + k), 1);
            chk("hf_s_lvl", 64'(s_level), 64'd8);
            chk("hf_f_lvl", 64'(f_level), 64'd8);
            chk("hf_s_rd", 64'(s_rd_data), (k < 8) ? 64'(8'h20 + k) : 64'(8'h40 + k - 8));
        end
        chk("hf_flags", 64'({s_of, s_uf, f_of, f_uf}), 64'd0);

        // mid-stream reset with 5 entries held
        cyc(1, 8'h00, 0);
        cyc(1, 8'h00, 0);
        cyc(1, 8'h00, 0);
        cyc(0, 8'h00, 1);
        for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1);
        chk("mr_lvl5", 64'(s_level), 64'd5);
        #2;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        #1;
        chk("mr_s_empty", 64'(s_empty), 64'd1);
        chk("mr_f_empty", 64'(f_empty), 64'd1);
        chk("mr_s_lvl",   64'(s_level), 64'd0);
        chk("mr_f_lvl",   64'(f_level), 64'd0);
        chk("mr_flags",   64'({s_of, s_uf, f_of, f_uf}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 8'h77, 0);
        cyc(0, 8'h00, 0);
        chk("mr_f_new", 64'(f_rd_data), 64'h77);
        cyc(0, 8'h00, 1);
        chk("mr_s_new", 64'(s_rd_data), 64'h77);
        chk("mr_empty", 64'(s_empty),   64'd1);

        // randomized traffic with biased phases to reach full and empty
        begin
            int pw [6] = '{80, 50, 20, 90, 10, 50};
            int pr [6] = '{20, 50, 80, 10, 90, 50};
            for (int p = 0; p < 6; p++) begin
                for (int c = 0; c < 250; c++) begin
                    cyc(($urandom_range(0, 99) < pw[p]), 8'($urandom), ($urandom_range(0, 99) < pr[p]));
                end
            end
        end
        cyc(0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
